mem_write_arbiter: RTL and testbench

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

---
 rtl/mem_write_arbiter_pkg.sv | 21 ++
 rtl/mem_write_arbiter_if.sv | 36 +++
 rtl/mem_write_arbiter_rr_arbiter.sv | 33 +++
 rtl/mem_write_arbiter.sv | 119 +++++++++++
 tb/tb_mem_write_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and constants for the memory write arbiter: FSM states,
// byte-count encodings and the legal-size check.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] BYTES_NONE = 3'd0;
    localparam logic [2:0] BYTE       = 3'd1;
    localparam logic [2:0] HALF       = 3'd2;
    localparam logic [2:0] WORD       = 3'd4;

    // Only byte, halfword and word writes ever reach the memory.
    function automatic logic is_legal_size(input logic [2:0] bytes);
        return (bytes == BYTE) || (bytes == HALF) || (bytes == WORD);
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Bundle of the two requester ports and the memory-side write port.
// The arbiter uses the slave view; requesters/memory use the master view.
interface mem_write_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr,  req1_addr;
    logic [DATA_W-1:0] req0_data,  req1_data;
    logic [2:0]        req0_bytes, req1_bytes;
    logic              resp0_valid, resp1_valid;
    logic              resp0_err,   resp1_err;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [2:0]        bytes_to_write;
    logic              write_activate;
    logic              write_done;
    logic              busy;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr,
               req0_data, req1_data, req0_bytes, req1_bytes, write_done,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_err, resp1_err, write_addr, write_data,
               bytes_to_write, write_activate, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr,
               req0_data, req1_data, req0_bytes, req1_bytes, write_done,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
               resp0_err, resp1_err, write_addr, write_data,
               bytes_to_write, write_activate, busy
    );
endinterface

// File: rtl/mem_write_arbiter_rr_arbiter.sv
// Two-way round-robin grant. The priority pointer only moves when a
// grant is actually taken (advance), so a request withdrawn before
// acceptance leaves fairness untouched.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_q;  // 0: requester 0 wins a tie, 1: requester 1 wins

    // One-hot grant from the current requests and the priority pointer.
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // Hand priority to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else if (advance) begin
            prio_q <= ~grant[1];
        end
    end
endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates two write requesters onto a single memory write port.
// One request in flight at a time: accept (IDLE), drive the memory
// (ISSUE) until write_done or timeout, then a one-cycle response (RESP).
// Illegal or zero byte counts bypass the memory and respond directly.
module mem_write_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst,
    mem_write_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic              err_q, err_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              grant_id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        bytes_q;
    logic [1:0]        req, grant;
    logic              accept, acc_id;
    logic [2:0]        sel_bytes;

    assign req       = {bus.req1_valid, bus.req0_valid};
    assign accept    = (state == IDLE) && (req != 2'b00);
    assign acc_id    = grant[1];
    assign sel_bytes = acc_id ? bus.req1_bytes : bus.req0_bytes;

    rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    assign bus.req0_ready     = (state == IDLE) && grant[0];
    assign bus.req1_ready     = (state == IDLE) && grant[1];
    assign bus.write_activate = (state == ISSUE);
    assign bus.bytes_to_write = (state == ISSUE) ? bytes_q : 3'd0;
    assign bus.write_addr     = addr_q;
    assign bus.write_data     = data_q;
    assign bus.resp0_valid    = (state == RESP) && !grant_id_q;
    assign bus.resp1_valid    = (state == RESP) &&  grant_id_q;
    assign bus.resp0_err      = bus.resp0_valid && err_q;
    assign bus.resp1_err      = bus.resp1_valid && err_q;
    assign bus.busy           = (state != IDLE);

    // Capture the winning request so the requester is free after accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_id_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            bytes_q    <= '0;
        end else if (accept) begin
            grant_id_q <= acc_id;
            addr_q     <= acc_id ? bus.req1_addr : bus.req0_addr;
            data_q     <= acc_id ? bus.req1_data : bus.req0_data;
            bytes_q    <= sel_bytes;
        end
    end

    // FSM state, response error flag and ISSUE timeout counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; write_done only matters while in ISSUE.
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = '0;
                    if (is_legal_size(sel_bytes)) begin
                        state_nxt = ISSUE;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt = RESP;
                        err_nxt   = (sel_bytes != BYTES_NONE);
                    end
                end
            end
            ISSUE: begin
                if (bus.write_done) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter with TIMEOUT=8.
module tb_mem_write_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_write_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_addr  = 32'h0;
        bus.req1_addr  = 32'h0;
        bus.req0_data  = 32'h0;
        bus.req1_data  = 32'h0;
        bus.req0_bytes = 3'd0;
        bus.req1_bytes = 3'd0;
        bus.write_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int g;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        // reset state
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_act", 64'(bus.write_activate), 64'd0);
        chk("rst_bytes", 64'(bus.bytes_to_write), 64'd0);
        chk("rst_addr", 64'(bus.write_addr), 64'd0);
        chk("rst_data", 64'(bus.write_data), 64'd0);
        chk("rst_resp", 64'({bus.resp1_valid, bus.resp0_valid, bus.resp1_err, bus.resp0_err}), 64'd0);
        rst = 1'b1;
        cyc();

        // single write, write_done on second ISSUE cycle
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 32'h0000_0100;
        bus.req0_data  = 32'hffff_ffff;
        bus.req0_bytes = 3'd4;
        #1;
        chk("sw_ready0", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 32'hdead_beef;
        bus.req0_data  = 32'h1234_5678;
        bus.req0_bytes = 3'd1;
        #1;
        chk("sw_act1", 64'(bus.write_activate), 64'd1);
        chk("sw_addr1", 64'(bus.write_addr), 64'h100);
        chk("sw_data1", 64'(bus.write_data), 64'hffff_ffff);
        chk("sw_bytes1", 64'(bus.bytes_to_write), 64'd4);
        chk("sw_busy", 64'(bus.busy), 64'd1);
        cyc();
        chk("sw_act2", 64'(bus.write_activate), 64'd1);
        chk("sw_addr2", 64'(bus.write_addr), 64'h100);
        chk("sw_bytes2", 64'(bus.bytes_to_write), 64'd4);
        chk("sw_resp_early", 64'(bus.resp0_valid), 64'd0);
        bus.write_done = 1'b1;
        cyc();
        bus.write_done = 1'b0;
        chk("sw_act_resp", 64'(bus.write_activate), 64'd0);
        chk("sw_bytes_resp", 64'(bus.bytes_to_write), 64'd0);
        chk("sw_resp", 64'({bus.resp1_valid, bus.resp0_valid, bus.resp0_err}), 64'b010);
        cyc();
        chk("sw_resp_gone", 64'(bus.resp0_valid), 64'd0);
        chk("sw_idle", 64'(bus.busy), 64'd0);

        // fresh pointer for contention
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // contention: both valid throughout, grants alternate 0,1,0,1
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 32'h0000_0100;
        bus.req1_addr  = 32'h0000_0104;
        bus.req0_data  = 32'haaaa_0000;
        bus.req1_data  = 32'hbbbb_1111;
        bus.req0_bytes = 3'd4;
        bus.req1_bytes = 3'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            chk("ct_grant", 64'({bus.req1_ready, bus.req0_ready}), (g == 0) ? 64'b01 : 64'b10);
            cyc();
            chk("ct_act", 64'(bus.write_activate), 64'd1);
            chk("ct_addr", 64'(bus.write_addr), (g == 0) ? 64'h100 : 64'h104);
            chk("ct_bytes", 64'(bus.bytes_to_write), (g == 0) ? 64'd4 : 64'd2);
            chk("ct_noready", 64'({bus.req1_ready, bus.req0_ready}), 64'b00);
            bus.write_done = 1'b1;
            cyc();
            bus.write_done = 1'b0;
            chk("ct_gap", 64'(bus.write_activate), 64'd0);
            chk("ct_resp", 64'({bus.resp1_valid, bus.resp0_valid}), (g == 0) ? 64'b01 : 64'b10);
            cyc();
        end
        idle_inputs();
        #1;

        // illegal size 3 from requester 1
        bus.req1_valid = 1'b1;
        bus.req1_bytes = 3'd3;
        bus.req1_addr  = 32'h0000_0300;
        #1;
        chk("il_ready1", 64'({bus.req1_ready, bus.req0_ready}), 64'b10);
        cyc();
        bus.req1_valid = 1'b0;
        chk("il_act", 64'(bus.write_activate), 64'd0);
        chk("il_bytes", 64'(bus.bytes_to_write), 64'd0);
        chk("il_resp", 64'({bus.resp1_valid, bus.resp1_err, bus.resp0_valid}), 64'b110);
        cyc();
        chk("il_idle", 64'({bus.busy, bus.resp1_valid}), 64'b00);
        // zero byte count
        bus.req1_valid = 1'b1;
        bus.req1_bytes = 3'd0;
        cyc();
        bus.req1_valid = 1'b0;
        chk("z_act", 64'(bus.write_activate), 64'd0);
        chk("z_resp", 64'({bus.resp1_valid, bus.resp1_err}), 64'b10);
        cyc();

        // stray write_done while idle
        bus.write_done = 1'b1;
        cyc();
        bus.write_done = 1'b0;
        chk("sd_busy", 64'(bus.busy), 64'd0);
        chk("sd_resp", 64'({bus.resp1_valid, bus.resp0_valid, bus.write_activate}), 64'd0);
        cyc();

        // timeout with write_done never arriving
        bus.req0_valid = 1'b1;
        bus.req0_bytes = 3'd1;
        bus.req0_addr  = 32'h0000_0200;
        cyc();
        bus.req0_valid = 1'b0;
        n = 0;
        while (bus.write_activate && n < 20) begin
            n++;
            cyc();
        end
        chk("to_cycles", 64'(n), 64'd8);
        chk("to_resp", 64'({bus.resp0_valid, bus.resp0_err}), 64'b11);
        cyc();
        chk("to_idle", 64'(bus.busy), 64'd0);

        // reset during ISSUE
        bus.req0_valid = 1'b1;
        bus.req0_bytes = 3'd4;
        bus.req0_addr  = 32'h0000_0400;
        cyc();
        bus.req0_valid = 1'b0;
        chk("rm_act", 64'(bus.write_activate), 64'd1);
        rst = 1'b0;
        cyc();
        chk("rm_act_drop", 64'(bus.write_activate), 64'd0);
        chk("rm_busy", 64'(bus.busy), 64'd0);
        chk("rm_addr", 64'(bus.write_addr), 64'd0);
        chk("rm_noresp", 64'({bus.resp1_valid, bus.resp0_valid}), 64'd0);
        rst = 1'b1;
        cyc();
        chk("rm_noresp2", 64'({bus.resp1_valid, bus.resp0_valid}), 64'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_bytes = 3'd2;
        bus.req1_bytes = 3'd4;
        bus.req0_addr  = 32'h0000_0500;
        bus.req1_addr  = 32'h0000_0504;
        #1;
        chk("rm_prio", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
        cyc();
        idle_inputs();
        #1;
        chk("rm_addr2", 64'(bus.write_addr), 64'h500);
        bus.write_done = 1'b1;
        cyc();
        bus.write_done = 1'b0;
        chk("rm_resp", 64'({bus.resp1_valid, bus.resp0_valid, bus.resp0_err}), 64'b010);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
